// File: rtl/jhash_feeder.sv
// jhash_feeder
// ------------
// Upstream stage of the lookup3 hash core. Collects a byte stream
// (valid/ready) into 12-byte blocks, presents each block on k0/k1/k2 with
// its byte count and a last-block flag, and holds it stable while the hash
// core runs (core_en high) until the core reports core_done.
//
// Build option:
//   JHASH_FEEDER_BSWAP_EN  defined   -> big-endian packing within each word
//                          undefined -> little-endian packing (default)
//
// Parameters:
//   MAX_MSG_BYTES  saturation value of the running message byte count
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   in_data    input byte
//   in_valid   in_data is valid
//   in_last    current byte is the final byte of the message
//   in_ready   feeder can accept a byte this cycle
//   k0/k1/k2   block bytes 0-3 / 4-7 / 8-11
//   length     valid bytes in the block (1..12), zero-extended
//   blk_last   block holds the message's final byte
//   core_en    block valid; hash core runs while high
//   core_done  hash core finished the current block (may be a level)
//   msg_bytes  running byte count of the current message (saturating)

module jhash_feeder #(
  parameter int MAX_MSG_BYTES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] k0,
  output logic [31:0] k1,
  output logic [31:0] k2,
  output logic [31:0] length,
  output logic        blk_last,
  output logic        core_en,
  input  logic        core_done,
  output logic [15:0] msg_bytes
);

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT,
    GAP
  } state_t;

  localparam logic [15:0] MSG_MAX = 16'(MAX_MSG_BYTES);

  state_t     state;
  logic [3:0] byte_idx;
  logic [4:0] lane_shift;
  logic       accept;

  // A byte is taken only while filling and only when the registered ready
  // was already high, so the first cycle after reset never accepts.
  always_comb begin
    accept = (state == FILL) && in_valid && in_ready;
  end

  // Bit position of the current byte inside its 32-bit word.
  always_comb begin
`ifdef JHASH_FEEDER_BSWAP_EN
    lane_shift = 5'd24 - {byte_idx[1:0], 3'b000};
`else
    lane_shift = {byte_idx[1:0], 3'b000};
`endif
  end

  // Single FSM with registered outputs. Bytes are written straight into the
  // k registers, which were cleared in GAP, so unused bytes read as zero.
  // k/length/blk_last only change in FILL and GAP and so stay frozen
  // through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      byte_idx  <= 4'd0;
      in_ready  <= 1'b0;
      k0        <= 32'd0;
      k1        <= 32'd0;
      k2        <= 32'd0;
      length    <= 32'd0;
      blk_last  <= 1'b0;
      core_en   <= 1'b0;
      msg_bytes <= 16'd0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            case (byte_idx[3:2])
              2'd0:    k0[lane_shift +: 8] <= in_data;
              2'd1:    k1[lane_shift +: 8] <= in_data;
              default: k2[lane_shift +: 8] <= in_data;
            endcase
            byte_idx <= byte_idx + 4'd1;
            if (msg_bytes < MSG_MAX) begin
              msg_bytes <= msg_bytes + 16'd1;
            end
            // Twelfth byte or end of message closes the block; both at
            // once still closes it only once.
            if ((byte_idx == 4'd11) || in_last) begin
              state    <= ISSUE;
              in_ready <= 1'b0;
              core_en  <= 1'b1;
              length   <= {28'd0, byte_idx + 4'd1};
              blk_last <= in_last;
            end
          end
        end

        ISSUE: begin
          // core_done seen here belongs to no block yet and is ignored.
          state <= WAIT;
        end

        WAIT: begin
          if (core_done) begin
            state   <= GAP;
            core_en <= 1'b0;
          end
        end

        GAP: begin
          k0       <= 32'd0;
          k1       <= 32'd0;
          k2       <= 32'd0;
          byte_idx <= 4'd0;
          if (blk_last) begin
            msg_bytes <= 16'd0;
          end
          state    <= FILL;
          in_ready <= 1'b1;
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
